// File: rtl/compute_unit_pkg.sv
// Shared opcode constants and instruction field helpers
// for the register-file compute unit.
package compute_unit_pkg;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LD  = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_AND = 4'h4;
   localparam logic [3:0] OP_OR  = 4'h5;
   localparam logic [3:0] OP_NOT = 4'h6;
   localparam logic [3:0] OP_XOR = 4'h7;
   localparam logic [3:0] OP_SHL = 4'h8;
   localparam logic [3:0] OP_SHR = 4'h9;
   localparam logic [3:0] OP_MOV = 4'hA;
   localparam logic [3:0] OP_CMP = 4'hB;

   // Register id fields are at most 16 bits wide.
   function automatic logic [15:0] f_fld(
      input logic [63:0] instr,
      input int          ra,
      input int          idx
   );
      logic [63:0] m;
      m = (64'd1 << ra) - 64'd1;
      f_fld = 16'((instr >> (idx * ra)) & m);
   endfunction

   function automatic logic [3:0] f_op(
      input logic [63:0] instr,
      input int          ra
   );
      f_op = 4'((instr >> (3 * ra)) & 64'hF);
   endfunction

   function automatic logic [15:0] f_tgt(
      input logic [63:0] instr,
      input int          ra
   );
      f_tgt = f_fld(instr, ra, 2);
   endfunction

   function automatic logic [15:0] f_src0(
      input logic [63:0] instr,
      input int          ra
   );
      f_src0 = f_fld(instr, ra, 1);
   endfunction

   function automatic logic [15:0] f_src1(
      input logic [63:0] instr,
      input int          ra
   );
      f_src1 = f_fld(instr, ra, 0);
   endfunction

endpackage

// File: rtl/compute_unit_pipe_alu.sv
// Combinational ALU: result, carry/borrow and
// writeback/illegal qualifiers for one instruction.
module cu_alu
   import compute_unit_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int IMM_W  = 8
) (
   input  logic [3:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [IMM_W-1:0]  imm,
   output logic [DATA_W-1:0] data,
   output logic              carry,
   output logic              writes,
   output logic              illegal
);

   logic [DATA_W:0]          sum;
   logic [DATA_W:0]          diff;
   logic [DATA_W+IMM_W-1:0]  ext;

   assign sum  = {1'b0, a} + {1'b0, b};
   assign diff = {1'b0, a} - {1'b0, b};
   assign ext  = {{DATA_W{1'b0}}, imm};

   // Opcode decode and datapath select
   always_comb begin
      data    = '0;
      carry   = 1'b0;
      writes  = 1'b0;
      illegal = 1'b0;
      unique case (1'b1)
         (op == OP_NOP): ;
         (op == OP_LD): begin
            data   = ext[DATA_W-1:0];
            writes = 1'b1;
         end
         (op == OP_ADD): begin
            data   = sum[DATA_W-1:0];
            carry  = sum[DATA_W];
            writes = 1'b1;
         end
         (op == OP_SUB): begin
            data   = diff[DATA_W-1:0];
            carry  = diff[DATA_W];
            writes = 1'b1;
         end
         (op == OP_AND): begin
            data   = a & b;
            writes = 1'b1;
         end
         (op == OP_OR): begin
            data   = a | b;
            writes = 1'b1;
         end
         (op == OP_NOT): begin
            data   = ~a;
            writes = 1'b1;
         end
         (op == OP_XOR): begin
            data   = a ^ b;
            writes = 1'b1;
         end
         (op == OP_SHL): begin
            data   = {a[DATA_W-2:0], 1'b0};
            carry  = a[DATA_W-1];
            writes = 1'b1;
         end
         (op == OP_SHR): begin
            data   = {1'b0, a[DATA_W-1:1]};
            carry  = a[0];
            writes = 1'b1;
         end
         (op == OP_MOV): begin
            data   = a;
            writes = 1'b1;
         end
         (op == OP_CMP): begin
            data  = diff[DATA_W-1:0];
            carry = diff[DATA_W];
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/compute_unit_pipe.sv
// Two-stage register-file compute unit: decode/operand
// read in S1, execute + writeback + result register in S2.
module compute_unit_pipe
   import compute_unit_pkg::*;
#(
   parameter  int DATA_W   = 8,
   parameter  int NUM_REGS = 16,
   localparam int RA       = $clog2(NUM_REGS),
   localparam int INSTR_W  = 4 + 3 * RA
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ena,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instr,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [DATA_W-1:0]  res_data,
   output logic [RA-1:0]      res_tgt,
   output logic               res_zero,
   output logic               res_carry,
   output logic               res_illegal,
   input  logic [RA-1:0]      dbg_addr,
   output logic [DATA_W-1:0]  dbg_data
);

   logic [DATA_W-1:0] regs [NUM_REGS];

   logic              adv;
   logic [3:0]        d_op;
   logic [RA-1:0]     d_tgt;
   logic [RA-1:0]     d_s0;
   logic [RA-1:0]     d_s1;
   logic [DATA_W-1:0] d_a;
   logic [DATA_W-1:0] d_b;

   logic              s1_valid;
   logic [3:0]        s1_op;
   logic [RA-1:0]     s1_tgt;
   logic [DATA_W-1:0] s1_a;
   logic [DATA_W-1:0] s1_b;
   logic [2*RA-1:0]   s1_imm;

   logic [DATA_W-1:0] x_data;
   logic              x_carry;
   logic              x_wr;
   logic              x_ill;
   logic              fwd;

   assign adv      = ena & ~(res_valid & ~res_ready);
   assign in_ready = adv & rst_n;
   assign dbg_data = regs[dbg_addr];

   assign d_op  = f_op(64'(in_instr), RA);
   assign d_tgt = RA'(f_tgt(64'(in_instr), RA));
   assign d_s0  = RA'(f_src0(64'(in_instr), RA));
   assign d_s1  = RA'(f_src1(64'(in_instr), RA));

   // The S2 result is written at the same edge that
   // latches the new operands, so forward it here.
   assign fwd = s1_valid & x_wr;

   // Operand read with bypass from the executing instruction
   always_comb begin
      d_a = regs[d_s0];
      d_b = regs[d_s1];
      if (fwd && (s1_tgt == d_s0)) d_a = x_data;
      if (fwd && (s1_tgt == d_s1)) d_b = x_data;
   end

   cu_alu #(
      .DATA_W (DATA_W),
      .IMM_W  (2 * RA)
   ) u_alu (
      .op      (s1_op),
      .a       (s1_a),
      .b       (s1_b),
      .imm     (s1_imm),
      .data    (x_data),
      .carry   (x_carry),
      .writes  (x_wr),
      .illegal (x_ill)
   );

   // S1 decode register: captures accepted instruction
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_op    <= '0;
         s1_tgt   <= '0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_imm   <= '0;
      end else if (adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_op  <= d_op;
            s1_tgt <= d_tgt;
            s1_a   <= d_a;
            s1_b   <= d_b;
            s1_imm <= {d_s0, d_s1};
         end
      end
   end

   // S2: writeback to the regfile and load the result beat
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
         res_valid   <= 1'b0;
         res_data    <= '0;
         res_tgt     <= '0;
         res_zero    <= 1'b0;
         res_carry   <= 1'b0;
         res_illegal <= 1'b0;
      end else if (adv) begin
         res_valid <= s1_valid;
         if (s1_valid) begin
            res_data    <= x_data;
            res_tgt     <= s1_tgt;
            res_zero    <= (x_data == '0);
            res_carry   <= x_carry;
            res_illegal <= x_ill;
            if (x_wr) regs[s1_tgt] <= x_data;
         end
      end
   end

endmodule
